// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU (master) and the memory responder (slave).
interface mem_responder_if;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_adr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_ready;

  modport master (
    output req_valid, req_write, req_adr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_adr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder: accepts one request at a time, waits a fixed
// number of cycles, performs the access and holds the response until consumed.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 256
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            cap_write;
  logic [7:0]      cap_adr;
  logic [7:0]      cap_wdata;
  logic            accept;
  logic            enter_resp;
  logic            acc_write;
  logic [7:0]      acc_adr;
  logic [7:0]      acc_wdata;
  logic [AW-1:0]   mem_idx;
  logic [7:0]      mem [DEPTH];

  // Next-state and wait-counter logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nx = S_RESP;
        else           cnt_nx   = cnt - 4'd1;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    enter_resp = (state_nx == S_RESP) && (state != S_RESP);
  end

  // Access operands: with zero wait states the access coincides with the
  // accepting edge, so the values being captured are used directly.
  always_comb begin
    acc_write = cap_write;
    acc_adr   = cap_adr;
    acc_wdata = cap_wdata;
    if (state == S_IDLE) begin
      acc_write = bus.req_write;
      acc_adr   = bus.req_adr;
      acc_wdata = bus.req_wdata;
    end
    mem_idx = AW'(32'(acc_adr) % DEPTH);
  end

  // Control state, captured request and response data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_adr   <= '0;
      cap_wdata <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_adr   <= bus.req_adr;
        cap_wdata <= bus.req_wdata;
      end
      if (enter_resp) begin
        bus.rsp_rdata <= acc_write ? acc_wdata : mem[mem_idx];
      end
    end
  end

  // Storage array; contents survive reset, writes are blocked while in reset
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_write) begin
      mem[mem_idx] <= acc_wdata;
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    busy          = (state != S_IDLE);
  end

endmodule
